// File: rtl/note_voice.sv
// note_voice: one synthesizer voice. Latches a note/duration from the song
// reader, fetches its phase step from an external synchronous frequency ROM,
// then advances a phase accumulator on each sample request until the note's
// beats are used up.
module note_voice #(
  parameter int PHASE_WIDTH = 22,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play,
  input  logic                   load_new_note,
  input  logic [5:0]             note,
  input  logic [5:0]             duration,
  input  logic                   beat,
  input  logic                   generate_next_sample,
  input  logic [PHASE_WIDTH-1:0] step_size,
  output logic [5:0]             rom_note,
  output logic [ADDR_WIDTH-1:0]  sample_addr,
  output logic                   new_sample_ready,
  output logic                   voice_done
);

  typedef enum logic [1:0] {IDLE, LOOKUP, PLAYING} state_t;

  state_t                 state, state_next;
  logic [5:0]             note_reg;
  logic [5:0]             remaining;
  logic [PHASE_WIDTH-1:0] step_reg;
  logic [PHASE_WIDTH-1:0] phase_acc;
  // LOOKUP spans two cycles: the ROM registers rom_note on the first edge and
  // its data is valid for capture on the second.
  logic                   rom_wait;

  assign rom_note    = note_reg;
  assign sample_addr = phase_acc[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign voice_done  = (state == IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: a load always wins; otherwise progress only while playing.
  always_comb begin
    state_next = state;
    if (load_new_note) begin
      state_next = LOOKUP;
    end else if (play) begin
      case (state)
        LOOKUP:  if (!rom_wait) state_next = (remaining == '0) ? IDLE : PLAYING;
        PLAYING: if (beat && remaining == 6'd1) state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  // Datapath: note latch, step capture, beat countdown and phase accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note_reg         <= '0;
      remaining        <= '0;
      step_reg         <= '0;
      phase_acc        <= '0;
      new_sample_ready <= 1'b0;
      rom_wait         <= 1'b0;
    end else begin
      new_sample_ready <= 1'b0;
      if (load_new_note) begin
        note_reg  <= note;
        remaining <= duration;
        phase_acc <= '0;
        rom_wait  <= 1'b1;
      end else if (play) begin
        case (state)
          LOOKUP: begin
            if (rom_wait) rom_wait <= 1'b0;
            else          step_reg <= (note_reg == '0) ? '0 : step_size;
          end
          PLAYING: begin
            if (generate_next_sample) begin
              phase_acc        <= phase_acc + step_reg;
              new_sample_ready <= 1'b1;
            end
            if (beat) remaining <= remaining - 6'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_voice.sv
// tb_note_voice: directed scenarios plus randomized traffic for note_voice,
// checked against a cycle-level behavioural model of the voice.
module tb_note_voice;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic        load_new_note = 1'b0;
  logic [5:0]  note = '0;
  logic [5:0]  duration = '0;
  logic        beat = 1'b0;
  logic        generate_next_sample = 1'b0;
  logic [21:0] step_size;
  logic [5:0]  rom_note;
  logic [9:0]  sample_addr;
  logic        new_sample_ready;
  logic        voice_done;

  int checks = 0;
  int errors = 0;

  logic [21:0] tab [64];

  note_voice #(.PHASE_WIDTH(22), .ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .play(play), .load_new_note(load_new_note),
    .note(note), .duration(duration), .beat(beat),
    .generate_next_sample(generate_next_sample), .step_size(step_size),
    .rom_note(rom_note), .sample_addr(sample_addr),
    .new_sample_ready(new_sample_ready), .voice_done(voice_done)
  );

  always #5 clk = ~clk;

  // Synchronous frequency ROM: data one cycle after the address.
  always @(posedge clk) step_size <= tab[rom_note];

  // Behavioural model: mode 0 idle, 1 looking up, 2 playing.
  int m_mode, m_lk, m_note, m_rem, m_step, m_phase, m_rdy;

  task automatic model_reset();
    m_mode = 0; m_lk = 0; m_note = 0; m_rem = 0; m_step = 0; m_phase = 0; m_rdy = 0;
  endtask

  task automatic model_step();
    m_rdy = 0;
    if (load_new_note) begin
      m_note = note; m_rem = duration; m_phase = 0; m_mode = 1; m_lk = 2;
    end else if (play) begin
      if (m_mode == 1) begin
        m_lk = m_lk - 1;
        if (m_lk == 0) begin
          m_step = (m_note == 0) ? 0 : int'(tab[m_note]);
          m_mode = (m_rem == 0) ? 0 : 2;
        end
      end else if (m_mode == 2) begin
        if (generate_next_sample) begin
          m_phase = (m_phase + m_step) % (1 << 22);
          m_rdy = 1;
        end
        if (beat) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_mode = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit ld, input int nt, input int du, input bit bt, input bit gs);
    load_new_note = ld; note = nt[5:0]; duration = du[5:0];
    beat = bt; generate_next_sample = gs;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++; if (voice_done !== 1'b1) begin errors++; $display("FAIL reset_done act=%b exp=1", voice_done); end
    checks++; if (rom_note !== 6'd0) begin errors++; $display("FAIL reset_rom_note act=%0d exp=0", rom_note); end
    checks++; if (sample_addr !== 10'd0) begin errors++; $display("FAIL reset_addr act=%0d exp=0", sample_addr); end
    checks++; if (new_sample_ready !== 1'b0) begin errors++; $display("FAIL reset_ready act=%b exp=0", new_sample_ready); end
    reset = 1'b0;
  endtask

  task automatic test_basic_note();
    play = 1'b1;
    cyc(1, 20, 3, 0, 0);
    checks++; if (voice_done !== 1'b0) begin errors++; $display("FAIL basic_load_done act=%b exp=0", voice_done); end
    checks++; if (rom_note !== 6'd20) begin errors++; $display("FAIL basic_rom_note act=%0d exp=20", rom_note); end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    checks++; if (sample_addr !== 10'd1) begin errors++; $display("FAIL basic_addr act=%0d exp=1", sample_addr); end
    for (int b = 1; b <= 3; b++) begin
      cyc(0, 0, 0, 1, 0);
      checks++;
      if (voice_done !== (b == 3)) begin errors++; $display("FAIL basic_beat%0d_done act=%b exp=%b", b, voice_done, (b == 3)); end
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_accumulation();
    logic [9:0] exp_addr [4];
    exp_addr[0] = 10'd512; exp_addr[1] = 10'd0; exp_addr[2] = 10'd512; exp_addr[3] = 10'd0;
    cyc(1, 5, 20, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 1);
      checks++; if (new_sample_ready !== 1'b1) begin errors++; $display("FAIL accum_ready%0d act=%b exp=1", k, new_sample_ready); end
      checks++; if (sample_addr !== exp_addr[k]) begin errors++; $display("FAIL accum_addr%0d act=%0d exp=%0d", k, sample_addr, exp_addr[k]); end
      cyc(0, 0, 0, 0, 0);
      checks++; if (new_sample_ready !== 1'b0) begin errors++; $display("FAIL accum_ready_drop%0d act=%b exp=0", k, new_sample_ready); end
    end
  endtask

  task automatic test_rest();
    cyc(1, 0, 2, 0, 0);
    checks++; if (rom_note !== 6'd0) begin errors++; $display("FAIL rest_rom_note act=%0d exp=0", rom_note); end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    checks++; if (new_sample_ready !== 1'b1) begin errors++; $display("FAIL rest_ready act=%b exp=1", new_sample_ready); end
    checks++; if (sample_addr !== 10'd0) begin errors++; $display("FAIL rest_addr act=%0d exp=0", sample_addr); end
    cyc(0, 0, 0, 1, 1);
    checks++; if (voice_done !== 1'b0) begin errors++; $display("FAIL rest_beat1_done act=%b exp=0", voice_done); end
    cyc(0, 0, 0, 1, 0);
    checks++; if (voice_done !== 1'b1) begin errors++; $display("FAIL rest_beat2_done act=%b exp=1", voice_done); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (new_sample_ready !== 1'b0) begin errors++; $display("FAIL rest_idle_ready act=%b exp=0", new_sample_ready); end
  endtask

  task automatic test_pause();
    logic [9:0] held;
    cyc(1, 7, 4, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    checks++; if (sample_addr !== 10'(m_phase / 4096)) begin errors++; $display("FAIL pause_pre_addr act=%0d exp=%0d", sample_addr, m_phase / 4096); end
    held = sample_addr;
    play = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 1);
      checks++; if (sample_addr !== held || new_sample_ready !== 1'b0 || voice_done !== 1'b0) begin
        errors++; $display("FAIL pause_hold%0d act=addr %0d rdy %b done %b exp=addr %0d rdy 0 done 0", i, sample_addr, new_sample_ready, voice_done, held);
      end
    end
    play = 1'b1;
    for (int b = 0; b < 3; b++) begin
      cyc(0, 0, 0, 1, 0);
      checks++; if (voice_done !== (b == 2)) begin errors++; $display("FAIL pause_resume%0d_done act=%b exp=%b", b, voice_done, (b == 2)); end
    end
  endtask

  task automatic test_simultaneous();
    cyc(1, 9, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 11, 2, 1, 1);
    checks++; if (voice_done !== 1'b0 || sample_addr !== 10'd0 || rom_note !== 6'd11 || new_sample_ready !== 1'b0) begin
      errors++; $display("FAIL simul_load act=done %b addr %0d note %0d rdy %b exp=done 0 addr 0 note 11 rdy 0", voice_done, sample_addr, rom_note, new_sample_ready);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    checks++; if (voice_done !== 1'b0) begin errors++; $display("FAIL simul_beat_done act=%b exp=0", voice_done); end
    cyc(1, 3, 0, 0, 0);
    checks++; if (voice_done !== 1'b0) begin errors++; $display("FAIL zero_dur_c1 act=%b exp=0", voice_done); end
    cyc(0, 0, 0, 0, 0);
    checks++; if (voice_done !== 1'b0) begin errors++; $display("FAIL zero_dur_c2 act=%b exp=0", voice_done); end
    cyc(0, 0, 0, 0, 0);
    checks++; if (voice_done !== 1'b1) begin errors++; $display("FAIL zero_dur_c3 act=%b exp=1", voice_done); end
  endtask

  task automatic test_mid_reset();
    cyc(1, 5, 9, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    checks++; if (sample_addr !== 10'd512) begin errors++; $display("FAIL mreset_pre_addr act=%0d exp=512", sample_addr); end
    #3 reset = 1'b1;
    #1;
    checks++; if (voice_done !== 1'b1 || sample_addr !== 10'd0 || rom_note !== 6'd0 || new_sample_ready !== 1'b0) begin
      errors++; $display("FAIL mreset_async act=done %b addr %0d note %0d rdy %b exp=done 1 addr 0 note 0 rdy 0", voice_done, sample_addr, rom_note, new_sample_ready);
    end
    model_reset();
    #1 reset = 1'b0;
    cyc(1, 20, 2, 0, 0);
    checks++; if (voice_done !== 1'b0 || rom_note !== 6'd20) begin
      errors++; $display("FAIL mreset_reload act=done %b note %0d exp=done 0 note 20", voice_done, rom_note);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) play = ~play;
      cyc(($urandom_range(0, 39) == 0), $urandom_range(0, 63), $urandom_range(0, 5),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
      checks++; if (voice_done !== (m_mode == 0)) begin errors++; $display("FAIL rand_done@%0d act=%b exp=%b", i, voice_done, (m_mode == 0)); end
      checks++; if (rom_note !== 6'(m_note)) begin errors++; $display("FAIL rand_note@%0d act=%0d exp=%0d", i, rom_note, m_note); end
      checks++; if (sample_addr !== 10'(m_phase / 4096)) begin errors++; $display("FAIL rand_addr@%0d act=%0d exp=%0d", i, sample_addr, m_phase / 4096); end
      checks++; if (new_sample_ready !== 1'(m_rdy)) begin errors++; $display("FAIL rand_ready@%0d act=%b exp=%0d", i, new_sample_ready, m_rdy); end
    end
  endtask

  initial begin
    for (int n = 0; n < 64; n++) tab[n] = 22'($urandom);
    tab[20] = 22'd1000;
    tab[5]  = 22'd2097152;
    test_reset();
    test_basic_note();
    test_accumulation();
    test_rest();
    test_pause();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_voice.md
NOTE_VOICE -- requirements
Module: note_voice

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 22, width of the phase accumulator.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, number of accumulator MSBs presented as the sample address.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port play, input, 1, run enable; low freezes all counters.
REQ-006 SHALL have port load_new_note, input, 1, one-cycle strobe (the song reader's new_noteN) that loads note/duration.
REQ-007 SHALL have port note, input, 6, note number; 0 = rest.
REQ-008 SHALL have port duration, input, 6, note length in beats.
REQ-009 SHALL have port beat, input, 1, one-cycle beat tick.
REQ-010 SHALL have port generate_next_sample, input, 1, one-cycle sample request strobe.
REQ-011 SHALL have port step_size, input, PHASE_WIDTH, phase increment returned by the external synchronous frequency ROM one cycle after rom_note is presented.
REQ-012 SHALL have port rom_note, output, 6, latched note driving the frequency ROM address.
REQ-013 SHALL have port sample_addr, output, ADDR_WIDTH, phase_acc[PHASE_WIDTH-1 -: ADDR_WIDTH].
REQ-014 SHALL have port new_sample_ready, output, 1, one-cycle pulse when sample_addr has been updated.
REQ-015 SHALL have port voice_done, output, 1, high when the voice is idle (feeds the song reader's voiceN_done).

Function
REQ-016 SHALL implement states IDLE, LOOKUP and PLAYING; voice_done = (state == IDLE).
REQ-017 SHALL, on load_new_note in any state, latch note into note_reg and duration into remaining, clear phase_acc to 0, and enter LOOKUP next cycle, regardless of play.
REQ-018 SHALL drive rom_note = note_reg at all times.
REQ-019 SHALL, in LOOKUP, capture step_size into step_reg (or 0 when note_reg == 0) and go to PLAYING, or to IDLE when remaining == 0.
REQ-020 SHALL, in PLAYING with play high and beat high, decrement remaining by 1; a decrement from 1 to 0 moves to IDLE on the same edge.
REQ-021 SHALL, with play low, hold remaining, phase_acc and state, except that load_new_note is still honoured (REQ-017).
REQ-022 SHALL give load_new_note priority over a simultaneous beat or generate_next_sample; the beat is discarded.
REQ-023 SHALL, in PLAYING with play and generate_next_sample high, set phase_acc <= phase_acc + step_reg modulo 2^PHASE_WIDTH (wraps silently, no carry out).
REQ-024 SHALL assert new_sample_ready for exactly one cycle, the cycle after each accumulator update of REQ-023, including rests (step 0).
REQ-025 SHALL NOT update phase_acc or pulse new_sample_ready in IDLE or LOOKUP.
REQ-026 SHALL make total note length exactly `duration` beat pulses counted while in PLAYING with play high.

Reset
REQ-027 SHALL, on reset asserted, immediately force state = IDLE, note_reg = 0, remaining = 0, step_reg = 0, phase_acc = 0 and new_sample_ready = 0, so that voice_done = 1, rom_note = 0 and sample_addr = 0.
REQ-028 SHALL abort any note in progress on mid-operation reset, and accept a load on the first clock edge after reset deasserts.

Verification
REQ-029 SHALL cover the basic note: play = 1, load note = 6'd20, duration = 3, step_size = 1000 in LOOKUP -> voice_done low for 3 beats, returns high on the edge of the 3rd beat.
REQ-030 SHALL cover accumulation: step = 2^21, 4 sample strobes -> sample_addr 512, 0 (wrap), 512, 0, each followed by a one-cycle new_sample_ready.
REQ-031 SHALL cover the rest: note = 0, duration = 2 -> sample_addr stays 0, new_sample_ready still pulses, voice_done returns high after 2 beats.
REQ-032 SHALL cover pause: play dropped mid-note for 5 beats -> remaining and sample_addr frozen; resume completes the remaining beats.
REQ-033 SHALL cover simultaneous events: load_new_note coincident with beat while PLAYING, remaining = 1 -> new note loads, no IDLE, phase cleared; load with duration = 0 -> voice_done low for 2 cycles only.
REQ-034 SHALL cover mid-note reset: async reset pulse between clock edges -> voice_done = 1 and sample_addr = 0 before the next edge.
